// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared FSM states, message framing constants and byte formatter
package uart_sched_pkg;
  typedef enum logic [2:0] {IDLE, CONV, ISSUE, WACK, WDONE, GAP} state_t;
  localparam int MSG_LEN = 12;
  localparam logic [7:0] ASC_C = 8'h43;
  localparam logic [7:0] ASC_H = 8'h48;
  localparam logic [7:0] ASC_0 = 8'h30;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_SP = 8'h20;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;
  function automatic logic [7:0] msg_byte(input logic [3:0] idx, input logic [2:0] ch, input logic [19:0] bcd);
    logic [7:0] b;
    b = ASC_LF;
    case (idx)
      4'd0: b = ASC_C;
      4'd1: b = ASC_H;
      4'd2: b = ASC_0 + {5'd0, ch};
      4'd3: b = ASC_COLON;
      4'd4: b = ASC_SP;
      4'd5: b = ASC_0 + {4'd0, bcd[19:16]};
      4'd6: b = ASC_0 + {4'd0, bcd[15:12]};
      4'd7: b = ASC_0 + {4'd0, bcd[11:8]};
      4'd8: b = ASC_0 + {4'd0, bcd[7:4]};
      4'd9: b = ASC_0 + {4'd0, bcd[3:0]};
      4'd10: b = ASC_CR;
      default: b = ASC_LF;
    endcase
    return b;
  endfunction
endpackage

// File: rtl/bin2bcd.sv
// bin2bcd: 16-bit binary to 5-digit BCD, shift-add-3, done pulses 17 clocks after start
module bin2bcd (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        done,
  output logic [19:0] bcd
);
  logic [15:0] sh_q, sh_d;
  logic [19:0] bcd_q, bcd_d, adj;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d, done_q, done_d;
  // load on start, then one add-3-and-shift step per clock for 16 clocks
  always_comb begin
    adj = '0;
    for (int i = 0; i < 5; i++)
      adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    sh_d = sh_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      sh_d = bin;
      bcd_d = '0;
      cnt_d = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      bcd_d = {adj[18:0], sh_q[15]};
      sh_d = {sh_q[14:0], 1'b0};
      cnt_d = cnt_q + 5'd1;
      busy_d = cnt_q != 5'd15;
      done_d = cnt_q == 5'd15;
    end
  end
  // conversion registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sh_q <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign done = done_q;
  assign bcd = bcd_q;
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler formatting "CHn: ddddd\r\n" messages onto a uart_tx byte port
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int GAP_CYC = 50_000,
  parameter int ACK_TO  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*16-1:0] val,
  output logic [N_REQ-1:0]    ack,
  output logic              tx_en,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              active,
  output logic              err_to
);
  state_t state_q, state_d;
  logic [2:0] ptr_q, ptr_d, ch_q, ch_d, off;
  logic [15:0] val_q, val_d;
  logic [3:0] idx_q, idx_d, pick, sum, p1;
  logic [31:0] to_q, to_d, gap_q, gap_d;
  logic [N_REQ-1:0] ack_q, ack_d, rot, tmp;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ*16-1:0] vsh;
  logic tx_en_q, tx_en_d, active_q, active_d, err_to_q, err_to_d, start_q, start_d, sent;
  logic [7:0] tx_data_q, tx_data_d;
  logic bcd_done;
  logic [19:0] bcd;
  bin2bcd u_bcd (
    .clk  (clk),
    .rst  (rst),
    .start(start_q),
    .bin  (val_q),
    .done (bcd_done),
    .bcd  (bcd)
  );
  // round-robin pick: rotate req so the search origin sits at bit 0, take the lowest set bit
  always_comb begin
    dbl = {req, req} >> ptr_q;
    rot = dbl[N_REQ-1:0];
    off = '0;
    tmp = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      tmp = rot >> i;
      if (tmp[0]) off = 3'(i);
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    pick = sum >= 4'(N_REQ) ? sum - 4'(N_REQ) : sum;
    p1 = pick + 4'd1;
    vsh = val >> {pick[2:0], 4'd0};
  end
  // message sequencing: grant, convert, then issue/acknowledge 12 bytes, then idle gap
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    ch_d = ch_q;
    val_d = val_q;
    idx_d = idx_q;
    to_d = to_q;
    gap_d = gap_q;
    ack_d = '0;
    tx_en_d = 1'b0;
    tx_data_d = tx_data_q;
    err_to_d = 1'b0;
    start_d = 1'b0;
    sent = 1'b0;
    case (state_q)
      IDLE: if (|rot) begin
        ack_d = N_REQ'(1) << pick;
        ch_d = pick[2:0];
        ptr_d = p1 >= 4'(N_REQ) ? 3'd0 : p1[2:0];
        val_d = vsh[15:0];
        start_d = 1'b1;
        state_d = CONV;
      end
      CONV: if (bcd_done) begin
        idx_d = '0;
        state_d = ISSUE;
      end
      ISSUE: if (!tx_busy) begin
        tx_en_d = 1'b1;
        tx_data_d = msg_byte(idx_q, ch_q, bcd);
        to_d = '0;
        state_d = WACK;
      end
      WACK: if (tx_busy) state_d = WDONE;
      else if (to_q == 32'(ACK_TO - 1)) begin
        err_to_d = 1'b1;
        sent = 1'b1;
      end else to_d = to_q + 32'd1;
      WDONE: sent = !tx_busy;
      GAP: if (gap_q + 32'd1 >= 32'(GAP_CYC)) state_d = IDLE;
      else gap_d = gap_q + 32'd1;
      default: state_d = IDLE;
    endcase
    if (sent) begin
      state_d = idx_q == 4'(MSG_LEN - 1) ? GAP : ISSUE;
      idx_d = idx_q + 4'd1;
      gap_d = '0;
    end
    active_d = state_d != IDLE;
  end
  // scheduler state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      ch_q <= '0;
      val_q <= '0;
      idx_q <= '0;
      to_q <= '0;
      gap_q <= '0;
      ack_q <= '0;
      tx_en_q <= 1'b0;
      tx_data_q <= '0;
      active_q <= 1'b0;
      err_to_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      ch_q <= ch_d;
      val_q <= val_d;
      idx_q <= idx_d;
      to_q <= to_d;
      gap_q <= gap_d;
      ack_q <= ack_d;
      tx_en_q <= tx_en_d;
      tx_data_q <= tx_data_d;
      active_q <= active_d;
      err_to_q <= err_to_d;
      start_q <= start_d;
    end
  end
  assign ack = ack_q;
  assign tx_en = tx_en_q;
  assign tx_data = tx_data_q;
  assign active = active_q;
  assign err_to = err_to_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: randomized self-checking bench with a message-level reference model
module tb_uart_tx_sched;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [16*N-1:0] val = '0;
  logic [N-1:0] ack;
  logic tx_en, tx_busy, active, err_to;
  logic [7:0] tx_data;
  logic bm_en = 1'b1;
  int bcnt = 0;
  int chk = 0;
  int pass = 0;
  int cyc = 0;
  int err_cnt = 0;
  int rr_ptr = 0;
  byte unsigned rx_q[$];
  int tx_cyc_q[$];
  logic [N-1:0] ack_q[$];
  int ack_cyc_q[$];

  uart_tx_sched #(.N_REQ(N), .GAP_CYC(10), .ACK_TO(8)) dut (
    .clk(clk), .rst(rst), .req(req), .val(val), .ack(ack),
    .tx_en(tx_en), .tx_data(tx_data), .tx_busy(tx_busy),
    .active(active), .err_to(err_to)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: busy rises one clock after tx_en and stays for 10 clocks
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst || !bm_en) bcnt <= 0;
    else if (tx_en) bcnt <= 10;
    else if (bcnt > 0) bcnt <= bcnt - 1;
  end
  assign tx_busy = bcnt != 0;

  always @(negedge clk) begin
    if (rst) begin
      rx_q.delete();
      tx_cyc_q.delete();
      ack_q.delete();
      ack_cyc_q.delete();
      err_cnt = 0;
    end else begin
      if (tx_en) begin rx_q.push_back(tx_data); tx_cyc_q.push_back(cyc); end
      if (ack != '0) begin ack_q.push_back(ack); ack_cyc_q.push_back(cyc); end
      if (err_to) err_cnt++;
    end
  end

  function automatic int rr_pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) if (r[(rr_ptr + k) % N]) return (rr_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [95:0] exp_msg(input int ch, input int v);
    string s;
    logic [95:0] r;
    s = $sformatf("CH%0d: %0d%0d%0d%0d%0d", ch, v / 10000, (v / 1000) % 10, (v / 100) % 10, (v / 10) % 10, v % 10);
    r = '0;
    for (int i = 0; i < 10; i++) r = {r[87:0], s.getc(i)};
    return {r[79:0], 8'h0d, 8'h0a};
  endfunction

  function automatic logic [95:0] got_msg(input int m);
    logic [95:0] r;
    r = '0;
    for (int i = 0; i < 12; i++) r = {r[87:0], (m * 12 + i < rx_q.size()) ? rx_q[m * 12 + i] : 8'h00};
    return r;
  endfunction

  task automatic wait_acks(input int n);
    for (int t = 0; t < 800 && ack_q.size() < n; t++) @(negedge clk);
  endtask

  task automatic wait_bytes(input int n);
    for (int t = 0; t < 3000 && rx_q.size() < n; t++) @(negedge clk);
  endtask

  task automatic wait_idle(input int n);
    for (int t = 0; t < 3000 && (rx_q.size() < n || active); t++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rr_ptr = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk++; if (ack !== '0) $display("FAIL reset_ack: got %b expected 0", ack); else pass++;
    chk++; if (tx_en !== 1'b0) $display("FAIL reset_tx_en: got %b expected 0", tx_en); else pass++;
    chk++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h expected 00", tx_data); else pass++;
    chk++; if (active !== 1'b0) $display("FAIL reset_active: got %b expected 0", active); else pass++;
    chk++; if (err_to !== 1'b0) $display("FAIL reset_err_to: got %b expected 0", err_to); else pass++;
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    bm_en = 1'b1;
    val[15:0] = 16'd1234;
    req = 4'b0001;
    wait_acks(1);
    req = '0;
    wait_idle(12);
    chk++; if (ack_q.size() != 1 || rx_q.size() != 12) $display("FAIL single_counts: got acks=%0d bytes=%0d expected 1/12", ack_q.size(), rx_q.size()); else pass++;
    chk++; if (ack_q.size() < 1 || ack_q[0] !== 4'b0001) $display("FAIL single_ack: got %b expected 0001", ack_q.size() ? ack_q[0] : 4'bx); else pass++;
    chk++; if (got_msg(0) !== exp_msg(0, 1234)) $display("FAIL single_msg: got %h expected %h", got_msg(0), exp_msg(0, 1234)); else pass++;
    chk++;
    if (tx_cyc_q.size() < 1 || ack_cyc_q.size() < 1 || tx_cyc_q[0] - ack_cyc_q[0] < 18)
      $display("FAIL single_latency: got %0d expected >=18", (tx_cyc_q.size() && ack_cyc_q.size()) ? tx_cyc_q[0] - ack_cyc_q[0] : -1);
    else pass++;
  endtask

  task automatic test_val_change();
    do_reset();
    val[15:0] = 16'd1234;
    req = 4'b0001;
    wait_acks(1);
    @(negedge clk);
    val[15:0] = 16'd9999;
    req = '0;
    wait_idle(12);
    chk++; if (got_msg(0) !== exp_msg(0, 1234)) $display("FAIL val_change_msg: got %h expected %h", got_msg(0), exp_msg(0, 1234)); else pass++;
  endtask

  task automatic test_extremes();
    do_reset();
    val[47:32] = 16'd65535;
    req = 4'b0100;
    wait_acks(1);
    req = '0;
    wait_idle(12);
    val[47:32] = 16'd0;
    req = 4'b0100;
    wait_acks(2);
    req = '0;
    wait_idle(24);
    chk++; if (got_msg(0) !== exp_msg(2, 65535)) $display("FAIL max_msg: got %h expected %h", got_msg(0), exp_msg(2, 65535)); else pass++;
    chk++; if (got_msg(1) !== exp_msg(2, 0)) $display("FAIL zero_msg: got %h expected %h", got_msg(1), exp_msg(2, 0)); else pass++;
  endtask

  task automatic test_round_robin();
    int chs[5];
    int c;
    do_reset();
    for (int i = 0; i < N; i++) val[16*i +: 16] = 16'($urandom);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_acks(k + 1);
      c = rr_pick(req);
      chs[k] = c;
      rr_ptr = (c + 1) % N;
      chk++;
      if (ack_q.size() < k + 1 || ack_q[k] !== 4'(1 << c))
        $display("FAIL rr_grant%0d: got %b expected %b", k, ack_q.size() > k ? ack_q[k] : 4'bx, 4'(1 << c));
      else pass++;
    end
    req = '0;
    wait_idle(60);
    for (int k = 0; k < 5; k++) begin
      chk++;
      if (got_msg(k) !== exp_msg(chs[k], int'(val[16*chs[k] +: 16])))
        $display("FAIL rr_msg%0d: got %h expected %h", k, got_msg(k), exp_msg(chs[k], int'(val[16*chs[k] +: 16])));
      else pass++;
    end
  endtask

  task automatic test_random();
    logic [N-1:0] m;
    int c, v;
    do_reset();
    for (int r = 0; r < 6; r++) begin
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) val[16*i +: 16] = 16'($urandom);
      req = m;
      wait_acks(r + 1);
      c = rr_pick(m);
      rr_ptr = (c + 1) % N;
      v = int'(val[16*c +: 16]);
      req = '0;
      chk++;
      if (ack_q.size() < r + 1 || ack_q[r] !== 4'(1 << c))
        $display("FAIL rand_grant%0d: got %b expected %b", r, ack_q.size() > r ? ack_q[r] : 4'bx, 4'(1 << c));
      else pass++;
      wait_idle(12 * (r + 1));
      chk++; if (got_msg(r) !== exp_msg(c, v)) $display("FAIL rand_msg%0d: got %h expected %h", r, got_msg(r), exp_msg(c, v)); else pass++;
    end
  endtask

  task automatic test_timeout();
    int v;
    do_reset();
    bm_en = 1'b0;
    v = int'($urandom_range(0, 65535));
    val[15:0] = 16'(v);
    req = 4'b0001;
    wait_acks(1);
    req = '0;
    wait_idle(12);
    chk++; if (err_cnt != 12) $display("FAIL to_err_count: got %0d expected 12", err_cnt); else pass++;
    chk++; if (rx_q.size() != 12 || active !== 1'b0) $display("FAIL to_tx_count: got %0d active=%b expected 12 active=0", rx_q.size(), active); else pass++;
    chk++; if (got_msg(0) !== exp_msg(0, v)) $display("FAIL to_msg: got %h expected %h", got_msg(0), exp_msg(0, v)); else pass++;
    bm_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int v;
    do_reset();
    val[15:0] = 16'($urandom);
    req = 4'b0001;
    wait_acks(1);
    req = '0;
    wait_bytes(5);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rr_ptr = 0;
    chk++; if (active !== 1'b0) $display("FAIL mid_active: got %b expected 0", active); else pass++;
    repeat (40) @(negedge clk);
    chk++; if (rx_q.size() != 0) $display("FAIL mid_no_tx: got %0d bytes expected 0", rx_q.size()); else pass++;
    v = int'($urandom_range(0, 65535));
    val[31:16] = 16'(v);
    req = 4'b0010;
    wait_acks(1);
    req = '0;
    chk++; if (ack_q.size() < 1 || ack_q[0] !== 4'b0010) $display("FAIL mid_next_grant: got %b expected 0010", ack_q.size() ? ack_q[0] : 4'bx); else pass++;
    wait_idle(12);
    chk++; if (got_msg(0) !== exp_msg(1, v)) $display("FAIL mid_next_msg: got %h expected %h", got_msg(0), exp_msg(1, v)); else pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_val_change();
    test_extremes();
    test_round_robin();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters, legal range 1..8.
REQ-002 SHALL have parameter GAP_CYC, default 50_000: idle clocks after each message before the next grant.
REQ-003 SHALL have parameter ACK_TO, default 1024: max clocks to wait for tx_busy rise after a byte issue.
REQ-004 SHALL have port clk  input  1  single system clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req  input  N_REQ  level request per channel.
REQ-007 SHALL have port val  input  N_REQ*16  16-bit value per channel; channel i at bits [16*i +: 16].
REQ-008 SHALL have port ack  output  N_REQ  one-cycle one-hot grant pulse; value latched on that cycle.
REQ-009 SHALL have port tx_en  output  1  one-cycle byte-issue strobe to uart_tx.
REQ-010 SHALL have port tx_data  output  8  byte, valid while tx_en=1.
REQ-011 SHALL have port tx_busy  input  1  uart_tx busy flag.
REQ-012 SHALL have port active  output  1  high from grant until gap end.
REQ-013 SHALL have port err_to  output  1  one-cycle pulse on ACK_TO expiry.

Function
REQ-014 SHALL format every message as 12 ASCII bytes: "CH", '0'+channel, ':', ' ', five decimal digits MSD first with leading zeros, CR (0x0D), LF (0x0A).
REQ-015 SHALL use states IDLE, CONV, ISSUE, WACK, WDONE, GAP.
REQ-016 IDLE: if any req bit is set, SHALL grant by round-robin starting at (last granted + 1) mod N_REQ, pulse ack, latch val, go to CONV; after reset the search starts at channel 0.
REQ-017 CONV: SHALL convert the latched 16-bit value to 5 BCD digits in exactly 17 clocks, then go to ISSUE with byte index 0.
REQ-018 ISSUE: when tx_busy=0, SHALL pulse tx_en for one cycle with the indexed byte, then go to WACK; while tx_busy=1, SHALL hold.
REQ-019 WACK: on tx_busy=1, SHALL go to WDONE; if ACK_TO clocks elapse first, SHALL pulse err_to and treat the byte as sent.
REQ-020 WDONE: on tx_busy=0, SHALL advance the index; index 11 done -> GAP, otherwise -> ISSUE.
REQ-021 GAP: SHALL count GAP_CYC clocks, then return to IDLE; GAP_CYC=0 SHALL return on the next clock.
REQ-022 req deasserted before its grant SHALL NOT be served; req held after ack SHALL be served again in a later round.
REQ-023 Changes on val or req after ack SHALL NOT affect the message in flight.
REQ-024 Simultaneous requests: exactly one ack bit SHALL pulse per message, and a channel SHALL NOT be granted twice while another requests continuously.
REQ-025 Value 65535 SHALL yield digits "65535"; value 0 SHALL yield "00000".
REQ-026 ack SHALL rise one clock after IDLE samples req; the first tx_en SHALL come no earlier than 18 clocks after ack.

Reset
REQ-027 rst=1 SHALL force state IDLE, round-robin pointer so the next search starts at channel 0, ack=0, tx_en=0, tx_data=0, active=0, err_to=0, and all counters=0.
REQ-028 rst mid-message SHALL abort the message: no further tx_en, and the partial message is not resumed.

Structure
REQ-029 SHALL place the state enum, message length (12), and ASCII constants ("CH", ':', ' ', CR, LF) in package uart_sched_pkg.
REQ-030 SHALL implement the conversion in one sub-module bin2bcd (shift-add-3, start/done handshake, 17-clock latency).
REQ-031 SHALL instantiate no UART; the parent connects tx_en, tx_data, and tx_busy to uart_tx send_en, send_data, and send_busy.

Verification
REQ-032 Drive req=0001, val0=1234, and a busy model (busy 1 clock after tx_en, for 10 clocks) -> bytes "CH0: 01234\r\n" and one ack pulse.
REQ-033 Drive req=1111 held with GAP_CYC=10 -> grant order 0,1,2,3,0, and each message shows the correct channel digit.
REQ-034 Drive val2=65535 then val2=0 -> "CH2: 65535\r\n" then "CH2: 00000\r\n".
REQ-035 Hold tx_busy at 0 permanently with ACK_TO=8 -> 12 err_to pulses, 12 tx_en pulses, and the FSM returns to IDLE.
REQ-036 Assert rst after byte 5 -> tx_en stays 0, active=0, and the next request for channel 1 is granted first.
REQ-037 Change val0 from 1234 to 9999 one clock after ack -> the message still reads 01234.
